// File: rtl/delay_chain_mem_pkg.sv
// Shared length type, clamp helper and RAM-path threshold for the
// programmable-length memory delay chain.
package delay_chain_mem_pkg;

  localparam int DEF_MAX_LEN = 64;
  localparam int LEN_W       = $clog2(DEF_MAX_LEN + 1);
  // Lengths at or above this go through the RAM; shorter ones use the bypass.
  localparam int RAM_MIN_LEN = 2;

  typedef logic [LEN_W-1:0] len_t;

  function automatic int clamp_len(input int req, input int max_len);
    return (req > max_len) ? max_len : req;
  endfunction

endpackage

// File: rtl/delay_chain_mem_var_ram.sv
// Single-port read-first register-file RAM with a registered read port.
// Only the output register is reset; the storage array powers up undefined.
module delay_chain_mem_var_ram #(
  parameter int WORDS = 64,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  // NOTE: storage has no reset so it maps onto RAM macros/LUT-RAM; only rdata is reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // NOTE: non-blocking assignment makes the read return the word before this write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (we) rdata <= mem[addr];
  end

endmodule

// File: rtl/delay_chain_mem_var.sv
// Multi-lane delay line of runtime-programmable length on a single-port RAM.
// Optional macro DELAY_CHAIN_MEM_VAR_PRIME_EN masks dout to zero until dout_vld.
module delay_chain_mem_var
  import delay_chain_mem_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CH      = 4,
  parameter int MAX_LEN = 64,
  parameter int DEF_LEN = 16,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             len_load,
  input  logic [LW-1:0]    len_in,
  input  logic [CH*DW-1:0] din,
  output logic [CH*DW-1:0] dout,
  output logic             dout_vld,
  output logic [LW-1:0]    cur_len,
  output logic             len_sat
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int W  = CH * DW;

  logic [LW-1:0] fill_cnt;
  logic [LW-1:0] fill_nxt;
  logic [LW-1:0] new_len;
  logic [AW-1:0] addr;
  logic [W-1:0]  byp_q;
  logic [W-1:0]  ram_q;
  logic [W-1:0]  dout_raw;
  logic          vld_q;
  logic          ram_path;
  logic          ram_we;
  logic          addr_wrap;

  assign new_len   = LW'(clamp_len(int'(len_in), MAX_LEN));
  assign ram_path  = (cur_len >= LW'(RAM_MIN_LEN));
  assign ram_we    = en && !len_load && ram_path;
  // cur_len-1 RAM slots plus the RAM output register give cur_len samples of delay.
  assign addr_wrap = (LW'(addr) == cur_len - LW'(2));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fill_nxt = fill_cnt;
    if (en && (fill_cnt != cur_len)) fill_nxt = fill_cnt + LW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_len  <= LW'(DEF_LEN);
      fill_cnt <= '0;
      vld_q    <= (DEF_LEN == 0);
      len_sat  <= 1'b0;
      addr     <= '0;
      byp_q    <= '0;
    end else if (len_load) begin
      // A load flushes the line and discards this cycle's sample.
      cur_len  <= new_len;
      fill_cnt <= '0;
      vld_q    <= (new_len == '0);
      len_sat  <= (int'(len_in) > MAX_LEN);
      addr     <= '0;
    end else begin
      len_sat  <= 1'b0;
      fill_cnt <= fill_nxt;
      vld_q    <= (fill_nxt == cur_len);
      if (ram_we) addr <= addr_wrap ? '0 : addr + AW'(1);
      if (en && (cur_len == LW'(1))) byp_q <= din;
    end
  end

  delay_chain_mem_var_ram #(
    .WORDS (MAX_LEN),
    .WIDTH (W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .addr  (addr),
    .wdata (din),
    .rdata (ram_q)
  );

  always_comb begin
    dout_raw = ram_q;
    if (cur_len == '0)         dout_raw = din;
    else if (cur_len == LW'(1)) dout_raw = byp_q;
  end

  assign dout_vld = vld_q;

`ifdef DELAY_CHAIN_MEM_VAR_PRIME_EN
  assign dout = vld_q ? dout_raw : '0;
`else
  assign dout = dout_raw;
`endif

endmodule

// File: tb/tb_delay_chain_mem_var.sv
// Scoreboard bench for delay_chain_mem_var: a sample-history model predicts each
// cycle's outputs; a negedge monitor pops and compares them.
module tb_delay_chain_mem_var;
  import delay_chain_mem_pkg::*;

  localparam int DW      = 8;
  localparam int CH      = 4;
  localparam int MAX_LEN = 64;
  localparam int DEF_LEN = 16;
  localparam int W       = CH * DW;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         len_load;
  len_t         len_in;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         dout_vld;
  len_t         cur_len;
  logic         len_sat;

  always #5 clk = ~clk;

  delay_chain_mem_var #(
    .DW (DW), .CH (CH), .MAX_LEN (MAX_LEN), .DEF_LEN (DEF_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .len_load (len_load),
    .len_in   (len_in),
    .din      (din),
    .dout     (dout),
    .dout_vld (dout_vld),
    .cur_len  (cur_len),
    .len_sat  (len_sat)
  );

  typedef struct {
    logic [W-1:0] dout;
    bit           vld;
    int           len;
    bit           sat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: every sample accepted since the last load, in order.
  int           m_len;
  int           m_cnt;
  bit           m_sat;
  logic [W-1:0] m_hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_len = DEF_LEN;
    m_cnt = 0;
    m_sat = 1'b0;
    m_hist.delete();
  endtask

  function automatic exp_t model_view(input logic [W-1:0] d);
    exp_t e;
    e.len = m_len;
    e.sat = m_sat;
    e.vld = (m_len == 0) || (m_cnt >= m_len);
    if (m_len == 0)  e.dout = d;
    else if (e.vld)  e.dout = m_hist[m_cnt - m_len];
    else             e.dout = '0;
    return e;
  endfunction

  // One clock: drive inputs, queue the expected view for this cycle, then advance the model.
  task automatic cycle(input bit e, input bit ld, input int li, input logic [W-1:0] d);
    en       = e;
    len_load = ld;
    len_in   = len_t'(li);
    din      = d;
    sb.push_back(model_view(d));
    @(posedge clk);
    #1;
    if (ld) begin
      m_len = (li > MAX_LEN) ? MAX_LEN : li;
      m_sat = (li > MAX_LEN);
      m_cnt = 0;
      m_hist.delete();
    end else begin
      m_sat = 1'b0;
      if (e) begin
        m_hist.push_back(d);
        m_cnt++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("cur_len", 32'(cur_len), 32'(e.len));
      check("dout_vld", 32'(dout_vld), 32'(e.vld));
      check("len_sat", 32'(len_sat), 32'(e.sat));
      if (e.vld) check("dout", dout, e.dout);
`ifdef DELAY_CHAIN_MEM_VAR_PRIME_EN
      else check("dout_masked", dout, '0);
`endif
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_cur_len"}, 32'(cur_len), 32'(DEF_LEN));
    check({tag, "_dout_vld"}, 32'(dout_vld), 32'(0));
    check({tag, "_dout"}, dout, '0);
    check({tag, "_len_sat"}, 32'(len_sat), 32'(0));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; len_load = 1'b0; len_in = '0; din = '0;
    model_reset();
    #12;
    check_reset_state("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Default length 16, distinct counting pattern per lane.
    for (int k = 1; k <= 40; k++)
      cycle(1'b1, 1'b0, 0, {8'(k) ^ 8'hC0, 8'(k) ^ 8'h80, 8'(k) ^ 8'h40, 8'(k)});

    // Lengths 0, 1 and 2 with random enables.
    for (int l = 0; l <= 2; l++) begin
      cycle(1'b1, 1'b1, l, $urandom);
      for (int i = 0; i < 14; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 0, $urandom);
    end

    // Length 5, enable one cycle in three.
    cycle(1'b0, 1'b1, 5, $urandom);
    for (int i = 0; i < 36; i++) cycle((i % 3) == 0, 1'b0, 0, $urandom);

    // Mid-stream shortening from 16 to 8 with en high on the load cycle.
    cycle(1'b1, 1'b1, 16, $urandom);
    for (int i = 0; i < 24; i++) cycle(1'b1, 1'b0, 0, $urandom);
    cycle(1'b1, 1'b1, 8, $urandom);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 0, $urandom);

    // Over-range request clamps to MAX_LEN; reloading the same length flushes.
    cycle(1'b1, 1'b1, MAX_LEN + 5, $urandom);
    for (int i = 0; i < 150; i++) cycle($urandom_range(0, 3) != 0, 1'b0, 0, $urandom);
    cycle(1'b1, 1'b1, MAX_LEN, $urandom);
    for (int i = 0; i < 80; i++) cycle(1'b1, 1'b0, 0, $urandom);

    // Asynchronous reset mid-stream, then the default delay again.
    cycle(1'b1, 1'b1, 3, $urandom);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 0, $urandom);
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    model_reset();
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 0, $urandom);

    // Random reloads across the full range, including over-range values.
    for (int r = 0; r < 12; r++) begin
      cycle(1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, MAX_LEN + 6), $urandom);
      for (int i = 0; i < 60; i++) cycle($urandom_range(0, 3) != 0, 1'b0, 0, $urandom);
    end

    cycle(1'b0, 1'b0, 0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
